// File: rtl/shift_pkg.sv
// Shared types and constants for the shifter operand-issue stage.
// SHIFT_OPERAND_SAT_EN adds the over-range "zero" flag to each stored request.
package shift_pkg;

  localparam int unsigned SHIFT_W     = 16;
  localparam int unsigned SHIFT_AMT_W = 4;

`ifdef SHIFT_OPERAND_SAT_EN
  typedef struct packed {
    logic [SHIFT_W-1:0]     a;
    logic [SHIFT_AMT_W-1:0] amt;
    logic                   left;
    logic                   zero;
  } shift_req_t;
`else
  typedef struct packed {
    logic [SHIFT_W-1:0]     a;
    logic [SHIFT_AMT_W-1:0] amt;
    logic                   left;
  } shift_req_t;
`endif

  // True when the raw amount cannot be encoded in SHIFT_AMT_W bits.
  function automatic logic is_over_range(input logic [SHIFT_W-1:0] b);
    return |b[SHIFT_W-1:SHIFT_AMT_W];
  endfunction

endpackage

// File: rtl/shift_operand_stage_if.sv
// Request/issue bundle between decode, the operand stage and the barrel shifter.
interface shift_operand_stage_if
  import shift_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) ();

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic               in_valid;
  logic               in_ready;
  logic [SHIFT_W-1:0] in_a;
  logic [SHIFT_W-1:0] in_b;
  logic               in_left;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [SHIFT_W-1:0] out_a;
  logic [SHIFT_W-1:0] out_b;
  logic               out_left;
  logic               out_zero;
  logic [CNT_W-1:0]   count;

  modport master (
    output in_valid, in_a, in_b, in_left, flush, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_left, out_zero, count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_left, flush, out_ready,
    output in_ready, out_valid, out_a, out_b, out_left, out_zero, count
  );

endinterface

// File: rtl/shift_req_fifo.sv
// Show-ahead synchronous FIFO of shift requests with flush; the head output
// holds the last presented entry while the FIFO is empty.
module shift_req_fifo
  import shift_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  shift_req_t                   i_data,
  output shift_req_t                   o_data_c,
  output logic                         o_full_c,
  output logic                         o_empty_c,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  shift_req_t       r_mem [DEPTH];
  shift_req_t       r_last;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Flush wins over everything; a full FIFO never accepts, even alongside a pop.
  assign w_push = i_push && !w_full  && !i_flush;
  assign w_pop  = i_pop  && !w_empty && !i_flush;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (!w_empty) begin
        r_last <= r_mem[r_rd_ptr];
      end
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        r_count <= w_count_nxt;
      end
    end
  end

  // Storage needs no reset: it is never observed while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_data_c  = w_empty ? r_last : r_mem[r_rd_ptr];
  assign o_full_c  = w_full;
  assign o_empty_c = w_empty;
  assign o_count   = r_count;

endmodule

// File: rtl/shift_operand_stage.sv
// Operand-issue stage ahead of the 16-bit barrel shifter: buffers requests and
// normalises amounts to 0..15. SHIFT_OPERAND_SAT_EN selects zero-forcing over modulo-16.
module shift_operand_stage
  import shift_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = SHIFT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_operand_stage_if.slave io_bus
);

  logic [WIDTH-1:0] w_in_a;
  shift_req_t       w_push_req;
  shift_req_t       w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_in_a = io_bus.in_a;

  // Normalise the amount at push time so the stored request is shifter-ready.
  always_comb begin
    w_push_req      = '0;
    w_push_req.a    = SHIFT_W'(w_in_a);
    w_push_req.left = io_bus.in_left;
`ifdef SHIFT_OPERAND_SAT_EN
    if (is_over_range(io_bus.in_b)) begin
      w_push_req.amt  = '0;
      w_push_req.zero = 1'b1;
    end else begin
      w_push_req.amt  = io_bus.in_b[SHIFT_AMT_W-1:0];
      w_push_req.zero = 1'b0;
    end
`else
    w_push_req.amt  = io_bus.in_b[SHIFT_AMT_W-1:0];
`endif
  end

  assign io_bus.in_ready  = !w_full && !io_bus.flush;
  assign io_bus.out_valid = !w_empty;
  assign w_push           = io_bus.in_valid  && io_bus.in_ready;
  assign w_pop            = io_bus.out_valid && io_bus.out_ready;

  shift_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_flush   (io_bus.flush),
    .i_data    (w_push_req),
    .o_data_c  (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count   (io_bus.count)
  );

  assign io_bus.out_a    = w_head.a;
  assign io_bus.out_b    = {{(SHIFT_W - SHIFT_AMT_W){1'b0}}, w_head.amt};
  assign io_bus.out_left = w_head.left;
`ifdef SHIFT_OPERAND_SAT_EN
  assign io_bus.out_zero = w_head.zero;
`else
  assign io_bus.out_zero = 1'b0;
`endif

endmodule

// File: doc/shift_operand_stage.md
# shift_operand_stage

Operand-issue stage that sits directly upstream of the 16-bit barrel shifter. It accepts shift requests (operand, amount, direction) over a valid/ready handshake and buffers them in a small FIFO. It normalises each shift amount into the 0..15 range the shifter decodes, and presents one registered request at a time to the shifter's `a`, `b` and `left` inputs. This removes the shifter's undefined behaviour for amounts above 15 and decouples the decode stage from the execute stage.

## Interface
- `DEPTH`, 2, number of buffered requests; power of two, minimum 2.
- `WIDTH`, 16, operand width; fixed at 16 for this CPU.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream request present.
- `in_ready`  out  1  stage can accept a request this cycle.
- `in_a`  in  16  operand to shift.
- `in_b`  in  16  raw shift amount.
- `in_left`  in  1  1 = shift left, 0 = logical shift right.
- `flush`  in  1  synchronous discard of all buffered requests.
- `out_valid`  out  1  head request valid toward the shifter.
- `out_ready`  in  1  downstream consumes the head this cycle.
- `out_a`  out  16  head operand; drives the shifter's `a`.
- `out_b`  out  16  normalised amount; upper 12 bits are always 0; drives the shifter's `b`.
- `out_left`  out  1  head direction; drives the shifter's `left`.
- `out_zero`  out  1  the shifter result must be replaced by 0 (over-range shift).
- `count`  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- FIFO behaviour:
  - Push when `in_valid && in_ready`.
  - Pop when `out_valid && out_ready`.
  - `in_ready = !full && !flush`.
  - `out_valid = !empty`.
- Outputs are show-ahead from registered storage. There is no combinational path from the `in_*` inputs to the `out_*` outputs.
- Amount normalisation is done at push time, and the normalised value is stored:
  - `in_b` ≤ 15: `out_b = {12'b0, in_b[3:0]}`, `out_zero = 0`.
  - `in_b` ≥ 16: handled as set out under Configuration.
- Occupancy updates:
  - Push and pop in the same cycle: `count` unchanged. The read pointer and write pointer both advance.
  - Full: `in_ready = 0`. A pop in the same cycle does not enable a push; there is no full-bypass.
  - Empty: a push makes the request visible at the outputs on the next cycle. There is no empty-bypass.
- Pointers wrap modulo `DEPTH`. `count` saturates logically at `DEPTH` because no push is ever accepted when full.
- `flush` high:
  - On the next edge, `count = 0` and both pointers are reset to 0.
  - Any pop or push in that cycle is discarded. `in_ready` is already 0.
  - Flush takes priority over all other events.
- When the stage is empty, `out_a`, `out_b`, `out_left` and `out_zero` hold the last head values. Consumers must qualify them with `out_valid`.

## Timing
- Reset values: `in_ready = 1`, `out_valid = 0`, `count = 0`, `out_a = 0`, `out_b = 0`, `out_left = 0`, `out_zero = 0`. Pointers = 0.
- Reset asserted mid-operation clears all state immediately, independent of `clk`.
- Latency is 1 cycle from an accepted push into an empty FIFO to `out_valid`.
- Throughput is 1 request per cycle in steady state when `DEPTH` ≥ 2.
- `in_ready` and `out_valid` are registered-state functions. `in_ready` also depends on `flush`, combinationally.

## Configuration
- Macro `SHIFT_OPERAND_SAT_EN`.
- Defined: `in_b` ≥ 16 stores `out_b = 0` and `out_zero = 1`. The downstream mux forces the result to 0, which gives a mathematically correct over-range shift.
- Undefined: `in_b` ≥ 16 stores `out_b = {12'b0, in_b[3:0]}`, i.e. modulo-16. `out_zero` is tied to 0 and no storage bit is allocated for it.

## Structure
- Package `shift_pkg`:
  - Constants: `SHIFT_W = 16`, `SHIFT_AMT_W = 4`.
  - Typedef `shift_req_t` = {`a[15:0]`, `amt[3:0]`, `left`, `zero`}.
- One sub-module: `shift_req_fifo`. It is a generic synchronous FIFO of `shift_req_t` with push, pop, flush, full, empty and count.
- The top level does normalisation, handshake mapping and the zero-extension of `amt` onto `out_b`.

## Test plan
- Reset, then push `a=16'h00F0`, `b=4`, `left=1` with `out_ready=1` → next cycle `out_valid=1`, `out_a=16'h00F0`, `out_b=4`, `out_left=1`, `out_zero=0`.
- With `SHIFT_OPERAND_SAT_EN` defined, push `b=16'd20` → `out_b=0`, `out_zero=1`. Without it → `out_b=4`, `out_zero=0`.
- Hold `out_ready=0` and push 3 requests with `DEPTH=2` → `in_ready=0` after 2, `count=2`. The third request is accepted only the cycle after the first pop.
- Back-to-back pushes with `out_ready=1` for 8 cycles → 8 requests out in order, `count` stays 1, pointers wrap cleanly.
- `count=2` plus `flush` and `in_valid` in the same cycle → next cycle `count=0`, `out_valid=0`, pushed request dropped.
- Assert `rst` asynchronously mid-stream with `count=1` → `out_valid` falls before the next edge, and all outputs take their reset values.
